// File: rtl/transmissor_estado_serial.sv
// Serializes a latched game-state snapshot into a 5-byte 8N1 UART frame:
// header, {nave_x,nave_y}, placar, {6'b0,vidas}, XOR checksum.
module transmissor_estado_serial #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [3:0] nave_x,
    input  logic [3:0] nave_y,
    input  logic [7:0] placar,
    input  logic [1:0] vidas,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int                BAUD_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_UM  = BAUD_W'(1);

    typedef enum logic [3:0] {
        OCIOSO = 4'd0,
        START  = 4'd1,
        DADOS  = 4'd2,
        STOP   = 4'd3,
        FIM    = 4'd4
    } estado_t;

    estado_t           r_estado;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [2:0]        r_byte;
    logic [3:0]        r_x;
    logic [3:0]        r_y;
    logic [7:0]        r_placar;
    logic [1:0]        r_vidas;
    logic              r_saida;
    logic              r_ocupado;
    logic              r_pronto;
    logic [3:0]        r_db;

    estado_t           w_prox_estado;
    logic [BAUD_W-1:0] w_prox_baud;
    logic [2:0]        w_prox_bit;
    logic [2:0]        w_prox_byte;
    logic              w_aceita;
    logic              w_fim_bit;
    logic [3:0]        w_prox_x;
    logic [3:0]        w_prox_y;
    logic [7:0]        w_prox_placar;
    logic [1:0]        w_prox_vidas;
    logic [7:0]        w_byte_atual;
    logic              w_prox_saida;

    function automatic logic [7:0] checksum(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] b3);
        return b1 ^ b2 ^ b3;
    endfunction

    function automatic logic [7:0] byte_quadro(input logic [2:0] idx, input logic [3:0] x,
                                               input logic [3:0] y, input logic [7:0] p,
                                               input logic [1:0] v);
        logic [7:0] b1;
        logic [7:0] b3;
        b1 = {x, y};
        b3 = {6'b000000, v};
        case (idx)
            3'd0:    return HEADER;
            3'd1:    return b1;
            3'd2:    return p;
            3'd3:    return b3;
            3'd4:    return checksum(b1, p, b3);
            default: return 8'hFF;
        endcase
    endfunction

    assign saida_serial = r_saida;
    assign ocupado      = r_ocupado;
    assign pronto       = r_pronto;
    assign db_estado    = r_db;

    assign w_fim_bit = (r_baud == BAUD_MAX);

    // Next-state and counter logic
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_baud   = r_baud;
        w_prox_bit    = r_bit;
        w_prox_byte   = r_byte;
        w_aceita      = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (enviar) begin
                    w_aceita      = 1'b1;
                    w_prox_estado = START;
                    w_prox_baud   = '0;
                    w_prox_bit    = 3'd0;
                    w_prox_byte   = 3'd0;
                end else begin
                    w_prox_estado = OCIOSO;
                end
            end
            START: begin
                if (w_fim_bit) begin
                    w_prox_estado = DADOS;
                    w_prox_baud   = '0;
                    w_prox_bit    = 3'd0;
                end else begin
                    w_prox_baud   = r_baud + BAUD_UM;
                end
            end
            DADOS: begin
                if (w_fim_bit) begin
                    w_prox_baud = '0;
                    if (r_bit == 3'd7) begin
                        w_prox_estado = STOP;
                        w_prox_bit    = 3'd0;
                    end else begin
                        w_prox_bit    = r_bit + 3'd1;
                    end
                end else begin
                    w_prox_baud = r_baud + BAUD_UM;
                end
            end
            STOP: begin
                if (w_fim_bit) begin
                    w_prox_baud = '0;
                    if (r_byte < 3'd4) begin
                        w_prox_byte   = r_byte + 3'd1;
                        w_prox_estado = START;
                    end else begin
                        w_prox_estado = FIM;
                    end
                end else begin
                    w_prox_baud = r_baud + BAUD_UM;
                end
            end
            FIM: begin
                w_prox_estado = OCIOSO;
            end
            default: begin
                w_prox_estado = OCIOSO;
                w_prox_baud   = '0;
                w_prox_bit    = 3'd0;
                w_prox_byte   = 3'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge as the state
    always_comb begin
        w_prox_x      = w_aceita ? nave_x : r_x;
        w_prox_y      = w_aceita ? nave_y : r_y;
        w_prox_placar = w_aceita ? placar : r_placar;
        w_prox_vidas  = w_aceita ? vidas  : r_vidas;
        w_byte_atual  = byte_quadro(w_prox_byte, w_prox_x, w_prox_y, w_prox_placar, w_prox_vidas);
        case (w_prox_estado)
            START:   w_prox_saida = 1'b0;
            DADOS:   w_prox_saida = w_byte_atual[w_prox_bit];
            default: w_prox_saida = 1'b1;
        endcase
    end

    // State, counters, latched snapshot and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= OCIOSO;
            r_baud    <= '0;
            r_bit     <= 3'd0;
            r_byte    <= 3'd0;
            r_x       <= 4'd0;
            r_y       <= 4'd0;
            r_placar  <= 8'd0;
            r_vidas   <= 2'd0;
            r_saida   <= 1'b1;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_db      <= 4'd0;
        end else begin
            r_estado  <= w_prox_estado;
            r_baud    <= w_prox_baud;
            r_bit     <= w_prox_bit;
            r_byte    <= w_prox_byte;
            r_x       <= w_prox_x;
            r_y       <= w_prox_y;
            r_placar  <= w_prox_placar;
            r_vidas   <= w_prox_vidas;
            r_saida   <= w_prox_saida;
            r_ocupado <= (w_prox_estado != OCIOSO);
            r_pronto  <= (w_prox_estado == FIM);
            r_db      <= w_prox_estado;
        end
    end

endmodule

// File: tb/tb_transmissor_estado_serial.sv
// Randomized self-checking bench for transmissor_estado_serial with CLKS_PER_BIT=4.
module tb_transmissor_estado_serial;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enviar;
    logic [3:0] nave_x;
    logic [3:0] nave_y;
    logic [7:0] placar;
    logic [1:0] vidas;
    logic       saida_serial;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fails  = 0;

    logic       cap_line [0:1023];
    logic       cap_pr   [0:1023];
    logic       cap_oc   [0:1023];
    logic [3:0] cap_db   [0:1023];

    transmissor_estado_serial #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clock(clock), .reset(reset), .enviar(enviar),
        .nave_x(nave_x), .nave_y(nave_y), .placar(placar), .vidas(vidas),
        .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Reference model: frame contents and the ideal line/state as a function of cycles since accept
    function automatic logic [39:0] model_frame(input logic [3:0] x, input logic [3:0] y,
                                                input logic [7:0] p, input logic [1:0] v);
        logic [7:0] b1, b3;
        b1 = {x, y};
        b3 = {6'b000000, v};
        return {b1 ^ p ^ b3, b3, p, b1, 8'hA5};
    endfunction

    function automatic logic model_line(input logic [39:0] f, input int k);
        int bi, pos;
        if (k < 0 || k >= 50 * CPB) return 1'b1;
        bi  = k / CPB;
        pos = bi % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return f[(bi / 10) * 8 + pos - 1];
    endfunction

    function automatic logic [3:0] model_state(input int k);
        int pos;
        if (k < 0 || k > 50 * CPB) return 4'd0;
        if (k == 50 * CPB) return 4'd4;
        pos = (k / CPB) % 10;
        if (pos == 0) return 4'd1;
        if (pos == 9) return 4'd3;
        return 4'd2;
    endfunction

    function automatic logic [7:0] decode(input int base, input int b);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = cap_line[base + (b * 10 + 1 + i) * CPB + CPB / 2];
        return d;
    endfunction

    function automatic int wave_errs(input logic [39:0] f, input int base, input int n);
        int e;
        e = 0;
        for (int k = 0; k < n; k++)
            if (cap_line[base+k] !== model_line(f, k) || cap_pr[base+k] !== (k == 50 * CPB) ||
                cap_oc[base+k] !== (k <= 50 * CPB) || cap_db[base+k] !== model_state(k))
                e++;
        return e;
    endfunction

    // Samples outputs on falling edges; k=0 is the cycle right after the accept edge
    task automatic capture(input int n, input int drop_at, input int chg_at,
                           input logic [3:0] nx, input logic [3:0] ny,
                           input logic [7:0] np, input logic [1:0] nv);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cap_line[k] = saida_serial;
            cap_pr[k]   = pronto;
            cap_oc[k]   = ocupado;
            cap_db[k]   = db_estado;
            if (k == drop_at) enviar = 1'b0;
            if (k == chg_at) begin
                nave_x = nx; nave_y = ny; placar = np; vidas = nv;
            end
        end
    endtask

    task automatic request(input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] p, input logic [1:0] v);
        @(negedge clock);
        nave_x = x; nave_y = y; placar = p; vidas = v;
        enviar = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enviar = 1'b0;
        nave_x = 4'd0; nave_y = 4'd0; placar = 8'd0; vidas = 2'd0;
        repeat (5) @(negedge clock);
        n_checks++; if (saida_serial !== 1'b1) begin n_fails++; $display("FAIL reset_saida: got %b want 1", saida_serial); end
        n_checks++; if (ocupado !== 1'b0) begin n_fails++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        n_checks++; if (pronto !== 1'b0) begin n_fails++; $display("FAIL reset_pronto: got %b want 0", pronto); end
        n_checks++; if (db_estado !== 4'd0) begin n_fails++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (saida_serial !== 1'b1 || ocupado !== 1'b0) begin
            n_fails++; $display("FAIL idle_after_reset: saida=%b ocupado=%b want 1/0", saida_serial, ocupado);
        end
    endtask

    task automatic test_single_frame;
        logic [39:0] f;
        logic [7:0]  want [5];
        int e, np, no;
        want = '{8'hA5, 8'h39, 8'h2C, 8'h02, 8'h17};
        f = model_frame(4'd3, 4'd9, 8'h2C, 2'd2);
        request(4'd3, 4'd9, 8'h2C, 2'd2);
        capture(203, 0, -1, 4'd0, 4'd0, 8'd0, 2'd0);
        e = wave_errs(f, 0, 203);
        n_checks++; if (e != 0) begin n_fails++; $display("FAIL single_wave: %0d cycles differ, want 0", e); end
        for (int b = 0; b < 5; b++) begin
            n_checks++;
            if (decode(0, b) !== want[b]) begin
                n_fails++; $display("FAIL single_byte%0d: got %h want %h", b, decode(0, b), want[b]);
            end
        end
        np = 0; no = 0;
        for (int k = 0; k < 203; k++) begin np += int'(cap_pr[k]); no += int'(cap_oc[k]); end
        n_checks++; if (np != 1 || cap_pr[200] !== 1'b1) begin n_fails++; $display("FAIL single_pronto: pulses=%0d at200=%b want 1/1", np, cap_pr[200]); end
        n_checks++; if (no != 201) begin n_fails++; $display("FAIL single_ocupado: high %0d cycles want 201", no); end
    endtask

    task automatic test_back_to_back;
        logic [39:0] f1, f2;
        logic [3:0]  x2, y2;
        logic [7:0]  p2;
        logic [1:0]  v2;
        int e1, e2;
        x2 = 4'($urandom); y2 = 4'($urandom); p2 = 8'($urandom); v2 = 2'($urandom);
        f1 = model_frame(4'd3, 4'd9, 8'h2C, 2'd2);
        f2 = model_frame(x2, y2, p2, v2);
        request(4'd3, 4'd9, 8'h2C, 2'd2);
        capture(404, 300, 50, x2, y2, p2, v2);
        e1 = wave_errs(f1, 0, 202);
        e2 = wave_errs(f2, 202, 202);
        n_checks++; if (e1 != 0) begin n_fails++; $display("FAIL busy_first_wave: %0d cycles differ, want 0", e1); end
        n_checks++; if (e2 != 0) begin n_fails++; $display("FAIL busy_second_wave: %0d cycles differ, want 0", e2); end
        n_checks++; if (cap_oc[201] !== 1'b0 || cap_line[201] !== 1'b1 || cap_oc[202] !== 1'b1) begin
            n_fails++; $display("FAIL busy_gap: oc201=%b line201=%b oc202=%b want 0/1/1", cap_oc[201], cap_line[201], cap_oc[202]);
        end
        for (int b = 0; b < 5; b++) begin
            n_checks++;
            if (decode(202, b) !== f2[b*8+:8]) begin
                n_fails++; $display("FAIL busy_byte%0d: got %h want %h", b, decode(202, b), f2[b*8+:8]);
            end
        end
    endtask

    task automatic test_checksum_zero;
        logic [39:0] f;
        int e;
        f = model_frame(4'd0, 4'd0, 8'd0, 2'd0);
        request(4'd0, 4'd0, 8'd0, 2'd0);
        capture(202, 0, -1, 4'd0, 4'd0, 8'd0, 2'd0);
        e = wave_errs(f, 0, 202);
        n_checks++; if (e != 0) begin n_fails++; $display("FAIL zero_wave: %0d cycles differ, want 0", e); end
        n_checks++; if (decode(0, 0) !== 8'hA5) begin n_fails++; $display("FAIL zero_header: got %h want a5", decode(0, 0)); end
        for (int b = 1; b < 5; b++) begin
            n_checks++;
            if (decode(0, b) !== 8'h00) begin n_fails++; $display("FAIL zero_byte%0d: got %h want 00", b, decode(0, b)); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] f;
        logic [3:0]  x;
        logic [7:0]  p;
        int e, np, no;
        x = 4'($urandom); p = 8'($urandom);
        f = model_frame(x, 4'd5, p, 2'd1);
        request(x, 4'd5, p, 2'd1);
        capture(90, 0, -1, 4'd0, 4'd0, 8'd0, 2'd0);
        e = wave_errs(f, 0, 90);
        n_checks++; if (e != 0) begin n_fails++; $display("FAIL rstmid_prefix: %0d cycles differ, want 0", e); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0) begin
            n_fails++; $display("FAIL rstmid_async: saida=%b ocupado=%b pronto=%b estado=%0d want 1/0/0/0",
                                saida_serial, ocupado, pronto, db_estado);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        np = 0; no = 0;
        for (int k = 0; k < 220; k++) begin
            @(negedge clock);
            np += int'(pronto); no += int'(ocupado);
        end
        n_checks++; if (np != 0 || no != 0) begin n_fails++; $display("FAIL rstmid_abandon: pronto=%0d ocupado=%0d cycles want 0/0", np, no); end
        f = model_frame(4'd7, x, ~p, 2'd3);
        request(4'd7, x, ~p, 2'd3);
        capture(202, 0, -1, 4'd0, 4'd0, 8'd0, 2'd0);
        e = wave_errs(f, 0, 202);
        n_checks++; if (e != 0) begin n_fails++; $display("FAIL rstmid_next_frame: %0d cycles differ, want 0", e); end
    endtask

    task automatic test_bit_width;
        logic [39:0] f;
        int mr[$], er[$];
        int run, bad;
        f = model_frame(4'($urandom), 4'($urandom), 8'hFF, 2'd3);
        request(f[11:8], f[15:12], 8'hFF, 2'd3);
        f = model_frame(f[11:8], f[15:12], 8'hFF, 2'd3);
        capture(202, 0, -1, 4'd0, 4'd0, 8'd0, 2'd0);
        run = 1;
        for (int k = 1; k < 50 * CPB; k++)
            if (cap_line[k] === cap_line[k-1]) run++;
            else begin mr.push_back(run); run = 1; end
        mr.push_back(run);
        run = CPB;
        for (int i = 1; i < 50; i++)
            if (model_line(f, i * CPB) == model_line(f, (i - 1) * CPB)) run += CPB;
            else begin er.push_back(run); run = CPB; end
        er.push_back(run);
        n_checks++; if (mr.size() != er.size()) begin n_fails++; $display("FAIL width_runs: got %0d runs want %0d", mr.size(), er.size()); end
        bad = 0;
        for (int i = 0; i < mr.size() && i < er.size(); i++) if (mr[i] != er[i]) bad++;
        n_checks++; if (bad != 0) begin n_fails++; $display("FAIL width_lengths: %0d runs of wrong length, want 0", bad); end
        n_checks++; if (cap_line[0] !== 1'b0 || cap_line[199] !== 1'b1 || cap_line[201] !== 1'b1) begin
            n_fails++; $display("FAIL width_edges: first=%b last=%b idle=%b want 0/1/1", cap_line[0], cap_line[199], cap_line[201]);
        end
    endtask

    task automatic test_random_frames;
        logic [39:0] f;
        logic [3:0]  x, y;
        logic [7:0]  p;
        logic [1:0]  v;
        int e;
        for (int n = 0; n < 4; n++) begin
            x = 4'($urandom); y = 4'($urandom); p = 8'($urandom); v = 2'($urandom);
            f = model_frame(x, y, p, v);
            request(x, y, p, v);
            capture(202, int'($urandom_range(0, 3)), int'($urandom_range(1, 190)),
                    ~x, ~y, ~p, ~v);
            e = wave_errs(f, 0, 202);
            n_checks++; if (e != 0) begin n_fails++; $display("FAIL rand%0d_wave: %0d cycles differ, want 0", n, e); end
            for (int b = 0; b < 5; b++) begin
                n_checks++;
                if (decode(0, b) !== f[b*8+:8]) begin
                    n_fails++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, b, decode(0, b), f[b*8+:8]);
                end
            end
            repeat (int'($urandom_range(0, 5))) @(negedge clock);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_checksum_zero;
        test_reset_mid_frame;
        test_bit_width;
        test_random_frames;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
